// File: rtl/mac_operand_feeder_pkg.sv
// Shared types and operand widths for the int4 x int8 MAC operand feeder.
package mac_feed_pkg;

   localparam int A_W   = 4;
   localparam int B_W   = 8;
   localparam int ACC_W = 26;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } feed_state_t;

endpackage

// File: rtl/mac_operand_feeder_op_fifo.sv
// Synchronous FIFO with registered occupancy; a word pushed in cycle t is poppable from t+1.
module op_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Extra pointer bit separates the full and empty cases when the indices match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
   assign pop_data = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers activation/weight beats and feeds the double int4 x int8 MAC one beat per cycle.
module mac_operand_feeder
   import mac_feed_pkg::*;
#(
   parameter int LEN_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [LEN_W-1:0]   len,
   output logic               busy,
   output logic               done,
   input  logic               a_valid,
   output logic               a_ready,
   input  logic [2*A_W-1:0]   a_data,
   input  logic               b_valid,
   output logic               b_ready,
   input  logic [2*B_W-1:0]   b_data,
   output logic               mac_clr,
   output logic               pulse,
   output logic [A_W-1:0]     out_a1,
   output logic [A_W-1:0]     out_a2,
   output logic [B_W-1:0]     out_b1,
   output logic [B_W-1:0]     out_b2
);

   feed_state_t        state;
   feed_state_t        state_next;
   logic [LEN_W-1:0]   cnt;
   logic [LEN_W-1:0]   len_q;
   logic               a_full;
   logic               a_empty;
   logic               b_full;
   logic               b_empty;
   logic [2*A_W-1:0]   a_head;
   logic [2*B_W-1:0]   b_head;
   logic               pop_p0;
   logic               last_pop_p0;

   op_fifo #(.WIDTH(2*A_W), .DEPTH(FIFO_DEPTH)) u_a_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (a_valid),
      .push_data (a_data),
      .pop       (pop_p0),
      .pop_data  (a_head),
      .full      (a_full),
      .empty     (a_empty)
   );

   op_fifo #(.WIDTH(2*B_W), .DEPTH(FIFO_DEPTH)) u_b_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (b_valid),
      .push_data (b_data),
      .pop       (pop_p0),
      .pop_data  (b_head),
      .full      (b_full),
      .empty     (b_empty)
   );

   assign a_ready = !a_full;
   assign b_ready = !b_full;

   // Stage 0: pop decision from registered state only, so no input reaches an output combinationally.
   assign pop_p0      = (state == ST_RUN) && !a_empty && !b_empty && (cnt < len_q);
   assign last_pop_p0 = pop_p0 && (({1'b0, cnt} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, len_q});

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start) state_next = ST_CLEAR;
         ST_CLEAR: state_next = (len_q == '0) ? ST_DONE : ST_RUN;
         ST_RUN:   if (last_pop_p0) state_next = ST_DRAIN;
         ST_DRAIN: state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         len_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         mac_clr <= 1'b0;
         pulse   <= 1'b0;
      end else begin
         state   <= state_next;
         busy    <= (state_next != ST_IDLE);
         done    <= (state_next == ST_DONE);
         mac_clr <= (state_next == ST_CLEAR);
         pulse   <= pop_p0;
         if (state == ST_IDLE && start) begin
            len_q <= len;
            cnt   <= '0;
         end else if (pop_p0) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Stage 1: operand registers hold across bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_a1 <= '0;
         out_a2 <= '0;
         out_b1 <= '0;
         out_b2 <= '0;
      end else if (pop_p0) begin
         out_a1 <= a_head[A_W-1:0];
         out_a2 <= a_head[2*A_W-1:A_W];
         out_b1 <= b_head[B_W-1:0];
         out_b2 <= b_head[2*B_W-1:B_W];
      end
   end

endmodule
